// File: rtl/rs_flip_flop.sv
// Bank of independent clocked RS cells with complementary outputs
// and a registered per-bit flag for the S=R=1 condition.
module rs_flip_flop #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      BOTH_POLICY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] illegal
);

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] ill_nxt;

    // Next value of a bit when both set and reset are requested.
    function automatic logic both_val(input logic q);
        logic v;
        case (BOTH_POLICY)
            0:       v = 1'b1;
            1:       v = 1'b0;
            2:       v = q;
            default: v = ~q;
        endcase
        return v;
    endfunction

    always_comb begin
        q_nxt   = Q;
        ill_nxt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            unique case (1'b1)
                (S[i] & R[i]): begin
                    q_nxt[i]   = both_val(Q[i]);
                    ill_nxt[i] = 1'b1;
                end
                (S[i] & ~R[i]): q_nxt[i] = 1'b1;
                (~S[i] & R[i]): q_nxt[i] = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Q       <= RESET_VALUE;
            illegal <= '0;
        end else begin
            Q       <= q_nxt;
            illegal <= ill_nxt;
        end
    end

    assign Qn = ~Q;

endmodule

// File: tb/tb_rs_flip_flop.sv
// Bench for rs_flip_flop: directed scenarios plus random traffic
// against a bitwise reference model across five configurations.
module tb_rs_flip_flop;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] s_in;
    logic [3:0] r_in;

    logic       q0, qn0, il0;
    logic [3:0] q1, qn1, il1;
    logic [3:0] q2, qn2, il2;
    logic [3:0] q3, qn3, il3;
    logic [3:0] q4, qn4, il4;

    rs_flip_flop d0 (
        .clk(clk), .rst(rst), .S(s_in[0]), .R(r_in[0]),
        .Q(q0), .Qn(qn0), .illegal(il0)
    );
    rs_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b0000), .BOTH_POLICY(1)) d1 (
        .clk(clk), .rst(rst), .S(s_in), .R(r_in),
        .Q(q1), .Qn(qn1), .illegal(il1)
    );
    rs_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b0000), .BOTH_POLICY(2)) d2 (
        .clk(clk), .rst(rst), .S(s_in), .R(r_in),
        .Q(q2), .Qn(qn2), .illegal(il2)
    );
    rs_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b0000), .BOTH_POLICY(3)) d3 (
        .clk(clk), .rst(rst), .S(s_in), .R(r_in),
        .Q(q3), .Qn(qn3), .illegal(il3)
    );
    rs_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b1010), .BOTH_POLICY(0)) d4 (
        .clk(clk), .rst(rst), .S(s_in), .R(r_in),
        .Q(q4), .Qn(qn4), .illegal(il4)
    );

    logic [11:0] obs[5];

    always_comb begin
        obs[0] = {3'b000, q0, 3'b000, qn0, 3'b000, il0};
        obs[1] = {q1, qn1, il1};
        obs[2] = {q2, qn2, il2};
        obs[3] = {q3, qn3, il3};
        obs[4] = {q4, qn4, il4};
    end

    logic [3:0] exp_q[5];
    logic [3:0] exp_il[5];
    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [3:0] mask_of(input int i);
        return (i == 0) ? 4'b0001 : 4'b1111;
    endfunction

    function automatic logic [3:0] rv_of(input int i);
        return (i == 4) ? 4'b1010 : 4'b0000;
    endfunction

    function automatic int pol_of(input int i);
        return (i < 4) ? i : 0;
    endfunction

    function automatic logic [11:0] want(input int i);
        logic [3:0] m;
        m = mask_of(i);
        return {exp_q[i] & m, ~exp_q[i] & m, exp_il[i] & m};
    endfunction

    // Each cell: untouched bits keep Q, lone S sets, lone R clears,
    // and S&R bits take the configured policy value.
    task automatic model_step();
        logic [3:0] m, both, only_s, quiet, pv;
        for (int i = 0; i < 5; i++) begin
            m      = mask_of(i);
            both   = s_in & r_in & m;
            only_s = s_in & ~r_in & m;
            quiet  = ~(s_in | r_in) & m;
            case (pol_of(i))
                0:       pv = 4'b1111;
                1:       pv = 4'b0000;
                2:       pv = exp_q[i];
                default: pv = ~exp_q[i];
            endcase
            exp_q[i]  = (exp_q[i] & quiet) | only_s | (both & pv);
            exp_il[i] = both;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            exp_q[i]  = rv_of(i);
            exp_il[i] = 4'b0000;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_in = '0; r_in = '0;
        #2 rst = 1'b0;
        #1 model_reset();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs[i] !== want(i)) begin
                n_fail++;
                $display("FAIL reset[%0d] got %b want %b", i, obs[i], want(i));
            end
        end
        s_in = 4'b1111;
        repeat (2) begin
            tick();
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (obs[i] !== want(i)) begin
                    n_fail++;
                    $display("FAIL reset_hold[%0d] got %b want %b",
                             i, obs[i], want(i));
                end
            end
        end
        s_in = '0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (q4 !== 4'b1010 || q0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got q0=%b q4=%b want 0/1010", q0, q4);
        end
    endtask

    task automatic test_set_reset();
        s_in = 4'b1111; r_in = '0;
        tick();
        n_checks++;
        if ({q0, qn0} !== 2'b10) begin
            n_fail++;
            $display("FAIL set_first got %b%b want 10", q0, qn0);
        end
        tick();
        s_in = '0; r_in = 4'b1111;
        tick();
        n_checks++;
        if ({q0, qn0} !== 2'b01) begin
            n_fail++;
            $display("FAIL clr_first got %b%b want 01", q0, qn0);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs[i] !== want(i)) begin
                n_fail++;
                $display("FAIL set_reset[%0d] got %b want %b", i, obs[i], want(i));
            end
        end
    endtask

    task automatic test_hold();
        for (int v = 0; v < 2; v++) begin
            s_in = (v == 0) ? 4'b1111 : 4'b0000;
            r_in = (v == 0) ? 4'b0000 : 4'b1111;
            tick();
            s_in = '0; r_in = '0;
            repeat (2) tick();
            n_checks++;
            if ({q0, il0} !== {(v == 0), 1'b0}) begin
                n_fail++;
                $display("FAIL hold%0d got q=%b il=%b want q=%0d il=0",
                         v, q0, il0, (v == 0));
            end
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (obs[i] !== want(i)) begin
                    n_fail++;
                    $display("FAIL hold[%0d] got %b want %b", i, obs[i], want(i));
                end
            end
        end
    endtask

    task automatic test_illegal();
        s_in = '0; r_in = 4'b1111;
        tick();
        s_in = 4'b1111;
        repeat (2) begin
            tick();
            n_checks++;
            if ({q0, il0} !== 2'b11) begin
                n_fail++;
                $display("FAIL illegal_on got q=%b il=%b want 1/1", q0, il0);
            end
        end
        s_in = '0; r_in = '0;
        tick();
        n_checks++;
        if ({q0, il0} !== 2'b10) begin
            n_fail++;
            $display("FAIL illegal_off got q=%b il=%b want 1/0", q0, il0);
        end
    endtask

    task automatic test_policy();
        s_in = 4'b1111; r_in = '0;
        tick();
        r_in = 4'b1111;
        tick();
        n_checks++;
        if ({q1, q2, q3} !== 12'h0F0) begin
            n_fail++;
            $display("FAIL policy got %b %b %b want 0000 1111 0000", q1, q2, q3);
        end
        tick();
        n_checks++;
        if ({q1, q2, q3, il3} !== 16'h0FFF) begin
            n_fail++;
            $display("FAIL toggle got %b %b %b il=%b want 0000 1111 1111 1111",
                     q1, q2, q3, il3);
        end
        s_in = '0; r_in = '0;
    endtask

    task automatic test_width();
        s_in = 4'b1111; r_in = '0;
        tick();
        rst = 1'b0;
        #1 model_reset();
        n_checks++;
        if ({q4, qn4} !== 8'b1010_0101) begin
            n_fail++;
            $display("FAIL width_reset got %b/%b want 1010/0101", q4, qn4);
        end
        #1 rst = 1'b1;
        s_in = 4'b0101; r_in = 4'b1000;
        tick();
        n_checks++;
        if ({q4, qn4} !== 8'b0111_1000) begin
            n_fail++;
            $display("FAIL width got %b/%b want 0111/1000", q4, qn4);
        end
    endtask

    task automatic test_async_mid();
        s_in = 4'b1111; r_in = '0;
        tick();
        r_in = 4'b1111;
        #2 rst = 1'b0;
        #1 model_reset();
        n_checks++;
        if ({q0, qn0, q3} !== 6'b010000) begin
            n_fail++;
            $display("FAIL async got q0=%b qn0=%b q3=%b want 0 1 0000",
                     q0, qn0, q3);
        end
        s_in = 4'b1111; r_in = '0;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs[i] !== want(i)) begin
                n_fail++;
                $display("FAIL async_hold[%0d] got %b want %b", i, obs[i], want(i));
            end
        end
        #1 rst = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            s_in = 4'($urandom);
            r_in = 4'($urandom);
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b0;
                #1 model_reset();
                #1 rst = 1'b1;
            end
            tick();
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (obs[i] !== want(i)) begin
                    n_fail++;
                    $display("FAIL random%0d[%0d] s=%b r=%b got %b want %b",
                             n, i, s_in, r_in, obs[i], want(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_reset();
        test_hold();
        test_illegal();
        test_policy();
        test_width();
        test_async_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_flip_flop.md
Name: rs_flip_flop

Overview:
Clocked set/reset storage element, WIDTH bits wide, with one independent RS cell per bit. All state updates occur on the rising edge of clk. The block includes an asynchronous active-low reset. It provides true and complementary outputs plus a per-bit flag marking the illegal S=R=1 condition. It is a generic control-path primitive: status latches, sticky flags, and handshake holding registers.

Parameters:
WIDTH, 1, number of independent RS cells (bits); legal range 1 or more.
RESET_VALUE, 0 (all bits), value loaded into Q while reset is asserted; WIDTH bits.
BOTH_POLICY, 0, response to S=R=1 per bit: 0 = set-dominant (Q<=1), 1 = reset-dominant (Q<=0), 2 = hold, 3 = toggle.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  reset, asynchronous and active-low (0 = reset).
S  input  WIDTH  per-bit set request, sampled on rising clk.
R  input  WIDTH  per-bit reset request, sampled on rising clk.
Q  output  WIDTH  stored state, registered.
Qn  output  WIDTH  bitwise complement of Q, combinational from Q.
illegal  output  WIDTH  per-bit flag, registered; 1 in the cycle after S=R=1 was sampled on that bit.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset:
  - rst=0 forces Q=RESET_VALUE, Qn=~RESET_VALUE and illegal=0 immediately, without waiting for a clock edge.
  - These values hold while rst=0, regardless of clk, S and R.
- Reset release:
  - Deassertion of rst (0->1) is taken with no clock-edge side effect.
  - The first rising clk with rst=1 performs a normal update.
  - Reset mid-operation discards state immediately, including any pending toggle.
- Per-bit update on rising clk with rst=1:
  - S=0, R=0: hold.
  - S=1, R=0: Q<=1.
  - S=0, R=1: Q<=0.
  - S=1, R=1: per BOTH_POLICY (set / clear / hold / invert).
- illegal bit:
  - Set for exactly one cycle (registered) on any edge where S=R=1 was sampled, independent of BOTH_POLICY.
  - Cleared on the next edge unless S=R=1 again.
- Latency: one clock from sampling S/R to the Q change. Qn tracks Q with no added latency.
- Invariant: Qn == ~Q at all times outside X propagation.
- Bit independence: bits never interact. Each bit of S/R affects only the same bit of Q, Qn and illegal.
- No combinational path from S/R to any output.
- Default configuration (WIDTH=1, RESET_VALUE=0, BOTH_POLICY=0) is the reference behaviour for the test plan.

Test Plan:
- Async reset: Q=1, then drive rst=0 between clock edges -> Q=0 and Qn=1 within the same time step, before any edge; values held over 2 edges with S=1.
- Set then reset (rst=1, S=1, R=0 for 2 edges) -> Q=1, Qn=0 after the first edge. Then S=0, R=1 for 2 edges -> Q=0, Qn=1 after the first edge.
- Hold: set Q=1, then S=0, R=0 for 2 edges -> Q stays 1 and illegal stays 0. Repeat with Q=0 -> stays 0.
- Illegal input, default policy: Q=0, S=1, R=1 for 2 edges -> Q=1 after the first edge, illegal=1 during those cycles. Then S=R=0 -> illegal returns to 0 on the next edge with Q=1 held.
- Policy sweep: BOTH_POLICY=1/2/3 with Q=1 and S=R=1 for one edge -> Q=0 / 1 / 0. Toggle case over 2 edges -> 0 then 1.
- Width/independence: WIDTH=4, RESET_VALUE=4'b1010, rst pulse -> Q=1010. Then S=0101, R=1000 -> Q=0111 and Qn=1000 after one edge.
